unified_mem_arbiter: RTL and testbench



---
 rtl/unified_mem_arbiter.sv | 128 ++++++++++++
 tb/tb_unified_mem_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported fixed-latency memory between the instruction fetch and the data load/store path.
// Latency: a store acks 2 cycles after the request is sampled, and a load or fetch acks MEM_LAT+2 cycles after it.
// Backpressure: one transaction is in flight at a time, and a requester holds req until its ack while stall_if/stall_mem freeze the pipe.
//
// Ports:
//   clock, resetn                      pipeline clock, async active-low reset
//   if_req/if_addr -> if_rdata/if_ack  fetch port (req held until ack)
//   dm_req/dm_we/dm_addr/dm_wdata      data port (load/store), dm_rdata/dm_ack back
//   mem_en/mem_we/mem_addr/mem_wdata   memory issue (one-cycle strobe), mem_rdata in
//   stall_if, stall_mem                combinational req & ~ack
module unified_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_mem
);

   generate
      if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_mem_lat
         $error("unified_mem_arbiter: MEM_LAT must be in 1..7");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

   state_t     state, state_nxt;
   logic [2:0] cnt;
   logic       last_i;   // 1 when the most recent grant went to fetch
   logic       win_d;    // owner of the transaction in flight: 1 = data port
   logic       we_r;     // transaction in flight is a store
   logic       grant_d, grant_i;

   // Data wins unless fetch is also waiting and data had the previous grant;
   // this makes the two ports alternate under continuous contention.
   assign grant_d = dm_req & (~if_req | last_i);
   assign grant_i = ~grant_d & if_req;

   assign stall_if  = if_req & ~if_ack;
   assign stall_mem = dm_req & ~dm_ack;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      if_ack    = 1'b0;
      dm_ack    = 1'b0;
      case (state)
         IDLE:  if (grant_d | grant_i) state_nxt = ISSUE;
         ISSUE: begin
            mem_en    = 1'b1;
            mem_we    = we_r;
            state_nxt = we_r ? ACK : WAIT;
         end
         WAIT:  if (cnt == 3'd1) state_nxt = ACK;
         ACK: begin
            if_ack    = ~win_d;
            dm_ack    = win_d;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         cnt       <= 3'd0;
         last_i    <= 1'b1;
         win_d     <= 1'b0;
         we_r      <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_d) begin
                  win_d     <= 1'b1;
                  we_r      <= dm_we;
                  mem_addr  <= dm_addr;
                  mem_wdata <= dm_wdata;
                  last_i    <= 1'b0;
               end else if (grant_i) begin
                  win_d    <= 1'b0;
                  we_r     <= 1'b0;
                  mem_addr <= if_addr;
                  last_i   <= 1'b1;
               end
            end
            ISSUE: if (!we_r) cnt <= 3'(MEM_LAT);
            WAIT: begin
               cnt <= cnt - 3'd1;
               // Count of 1 marks the cycle in which the memory drives valid data.
               if (cnt == 3'd1) begin
                  if (win_d) dm_rdata <= mem_rdata;
                  else       if_rdata <= mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;
   localparam int NI = 3;   // instances with MEM_LAT = 2, 1, 7

   logic        clock = 1'b0;
   logic        resetn;
   logic        if_req[NI], if_ack[NI], dm_req[NI], dm_we[NI], dm_ack[NI];
   logic        mem_en[NI], mem_we[NI], stall_if[NI], stall_mem[NI];
   logic [31:0] if_addr[NI], if_rdata[NI], dm_addr[NI], dm_wdata[NI], dm_rdata[NI];
   logic [31:0] mem_addr[NI], mem_wdata[NI], mem_rdata[NI];
   logic [31:0] mem_resp[NI][256];   // memory behind each DUT, written by DUT stores
   logic [31:0] refm[NI][256];       // reference memory, written by the model's grants
   int          total = 0;
   int          bad = 0;

   always #5 clock = ~clock;

   function automatic int lat_of(int k);
      return (k == 0) ? 2 : (k == 1) ? 1 : 7;
   endfunction

   function automatic logic [31:0] rnd_addr();
      return 32'($urandom_range(0, 255)) << 2;
   endfunction

   generate
      for (genvar k = 0; k < NI; k++) begin : g_dut
         localparam int LAT = (k == 0) ? 2 : (k == 1) ? 1 : 7;
         int         pend;
         logic [7:0] paddr;

         unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
            .clock(clock), .resetn(resetn),
            .if_req(if_req[k]), .if_addr(if_addr[k]), .if_rdata(if_rdata[k]), .if_ack(if_ack[k]),
            .dm_req(dm_req[k]), .dm_we(dm_we[k]), .dm_addr(dm_addr[k]), .dm_wdata(dm_wdata[k]),
            .dm_rdata(dm_rdata[k]), .dm_ack(dm_ack[k]),
            .mem_en(mem_en[k]), .mem_we(mem_we[k]), .mem_addr(mem_addr[k]), .mem_wdata(mem_wdata[k]),
            .mem_rdata(mem_rdata[k]), .stall_if(stall_if[k]), .stall_mem(stall_mem[k]));

         // Memory model: read data is valid only in the cycle LAT cycles after
         // the issue cycle; every other cycle carries random junk.
         always @(negedge clock or negedge resetn) begin
            if (!resetn) begin
               pend = 0;
               mem_rdata[k] = $urandom;
            end else begin
               if (pend > 0) begin
                  pend = pend - 1;
                  mem_rdata[k] = (pend == 0) ? mem_resp[k][paddr] : $urandom;
               end else begin
                  mem_rdata[k] = $urandom;
               end
               if (mem_en[k] === 1'b1) begin
                  if (mem_we[k]) mem_resp[k][mem_addr[k][9:2]] = mem_wdata[k];
                  else begin
                     pend  = LAT;
                     paddr = mem_addr[k][9:2];
                  end
               end
            end
         end
      end
   endgenerate

   task automatic clear_reqs();
      for (int k = 0; k < NI; k++) begin
         if_req[k] = 0; dm_req[k] = 0; dm_we[k] = 0;
         if_addr[k] = 0; dm_addr[k] = 0; dm_wdata[k] = 0;
      end
   endtask

   // Leaves the bench at a falling edge with resetn just released: cycle 0.
   task automatic do_reset();
      @(negedge clock);
      clear_reqs();
      resetn = 0;
      repeat (2) @(negedge clock);
      resetn = 1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clock);
      #1;
      for (int k = 0; k < NI; k++) begin
         total++;
         if ({mem_en[k], mem_we[k], if_ack[k], dm_ack[k], stall_if[k], stall_mem[k]} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl k=%0d got %b want 000000", k,
                     {mem_en[k], mem_we[k], if_ack[k], dm_ack[k], stall_if[k], stall_mem[k]});
         end
         total++;
         if ({mem_addr[k], mem_wdata[k], if_rdata[k], dm_rdata[k]} !== 128'b0) begin
            bad++;
            $display("FAIL reset_data k=%0d got %h %h %h %h want 0", k,
                     mem_addr[k], mem_wdata[k], if_rdata[k], dm_rdata[k]);
         end
      end
   endtask

   task automatic test_single_fetch();
      do_reset();
      if_req[0] = 1; if_addr[0] = 32'h10;
      for (int c = 0; c < 7; c++) begin
         if (c > 0) @(negedge clock);
         #1;
         total++;
         if (mem_en[0] !== 1'(c == 1)) begin
            bad++; $display("FAIL fetch_mem_en c=%0d got %b want %b", c, mem_en[0], c == 1);
         end
         if (c == 1) begin
            total++;
            if (mem_addr[0] !== 32'h10 || mem_we[0] !== 1'b0) begin
               bad++; $display("FAIL fetch_issue got addr=%h we=%b want addr=00000010 we=0", mem_addr[0], mem_we[0]);
            end
         end
         total++;
         if (if_ack[0] !== 1'(c == 4)) begin
            bad++; $display("FAIL fetch_ack c=%0d got %b want %b", c, if_ack[0], c == 4);
         end
         if (c == 4) begin
            total++;
            if (if_rdata[0] !== 32'h8C010004) begin
               bad++; $display("FAIL fetch_rdata got %h want 8c010004", if_rdata[0]);
            end
         end
         total++;
         if (stall_if[0] !== 1'(c <= 3)) begin
            bad++; $display("FAIL fetch_stall c=%0d got %b want %b", c, stall_if[0], c <= 3);
         end
         if (if_ack[0]) if_req[0] = 0;
      end
   endtask

   task automatic test_store();
      do_reset();
      dm_req[0] = 1; dm_we[0] = 1; dm_addr[0] = 32'h40; dm_wdata[0] = 32'hDEADBEEF;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) @(negedge clock);
         #1;
         total++;
         if (mem_en[0] !== 1'(c == 1)) begin
            bad++; $display("FAIL store_mem_en c=%0d got %b want %b", c, mem_en[0], c == 1);
         end
         if (c == 1) begin
            total++;
            if (mem_we[0] !== 1'b1 || mem_addr[0] !== 32'h40 || mem_wdata[0] !== 32'hDEADBEEF) begin
               bad++; $display("FAIL store_issue got we=%b addr=%h wdata=%h want 1 00000040 deadbeef",
                               mem_we[0], mem_addr[0], mem_wdata[0]);
            end
         end
         total++;
         if (dm_ack[0] !== 1'(c == 2) || if_ack[0] !== 1'b0) begin
            bad++; $display("FAIL store_ack c=%0d got dm=%b if=%b want dm=%b if=0", c, dm_ack[0], if_ack[0], c == 2);
         end
         if (dm_ack[0]) dm_req[0] = 0;
      end
      total++;
      if (mem_resp[0][16] !== 32'hDEADBEEF) begin
         bad++; $display("FAIL store_mem got %h want deadbeef", mem_resp[0][16]);
      end
   endtask

   task automatic test_collision();
      int          g_cyc[$];
      logic [31:0] g_addr[$];
      int          ndack = 0;
      int          ec[3] = '{1, 6, 11};
      logic [31:0] ea[3] = '{32'h80, 32'h20, 32'h84};
      do_reset();
      if_req[0] = 1; if_addr[0] = 32'h20;
      dm_req[0] = 1; dm_we[0] = 0; dm_addr[0] = 32'h80;
      for (int c = 0; c < 18; c++) begin
         if (c > 0) @(negedge clock);
         #1;
         if (mem_en[0]) begin g_cyc.push_back(c); g_addr.push_back(mem_addr[0]); end
         if (dm_ack[0]) begin
            ndack++;
            total++;
            if (dm_rdata[0] !== mem_resp[0][dm_addr[0][9:2]]) begin
               bad++; $display("FAIL coll_dm_rdata c=%0d got %h want %h", c, dm_rdata[0], mem_resp[0][dm_addr[0][9:2]]);
            end
            if (ndack == 1) dm_addr[0] = 32'h84;
            else begin dm_req[0] = 0; if_req[0] = 0; end
         end
         if (if_ack[0]) begin
            total++;
            if (if_rdata[0] !== mem_resp[0][8]) begin
               bad++; $display("FAIL coll_if_rdata c=%0d got %h want %h", c, if_rdata[0], mem_resp[0][8]);
            end
            if_addr[0] = 32'h24;
         end
      end
      total++;
      if (g_cyc.size() != 3) begin
         bad++; $display("FAIL coll_grants got %0d want 3", g_cyc.size());
      end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (i >= g_cyc.size() || g_cyc[i] != ec[i] || g_addr[i] !== ea[i]) begin
            bad++; $display("FAIL coll_order grant=%0d got cyc=%0d addr=%h want cyc=%0d addr=%h",
                            i, (i < g_cyc.size()) ? g_cyc[i] : -1, (i < g_addr.size()) ? g_addr[i] : 32'hx, ec[i], ea[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 1; k < NI; k++) begin
         int acks[$];
         int lat = lat_of(k);
         do_reset();
         dm_req[k] = 1; dm_we[k] = 0; dm_addr[k] = rnd_addr();
         for (int c = 0; c < 4 * (lat + 3) + 4; c++) begin
            if (c > 0) @(negedge clock);
            #1;
            if (dm_ack[k]) begin
               acks.push_back(c);
               total++;
               if (dm_rdata[k] !== mem_resp[k][dm_addr[k][9:2]]) begin
                  bad++; $display("FAIL b2b_rdata lat=%0d c=%0d got %h want %h", lat, c, dm_rdata[k], mem_resp[k][dm_addr[k][9:2]]);
               end
               if (acks.size() == 3) dm_req[k] = 0;
               else dm_addr[k] = rnd_addr();
            end
         end
         total++;
         if (acks.size() != 3 || acks[0] != lat + 2 || acks[1] - acks[0] != lat + 3 || acks[2] - acks[1] != lat + 3) begin
            bad++; $display("FAIL b2b_spacing lat=%0d got n=%0d first=%0d want n=3 first=%0d spacing=%0d",
                            lat, acks.size(), (acks.size() > 0) ? acks[0] : -1, lat + 2, lat + 3);
         end
      end
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      dm_req[0] = 1; dm_we[0] = 0; dm_addr[0] = 32'h100;
      repeat (2) @(negedge clock);   // cycle 2: first WAIT cycle
      #1;
      resetn = 0;
      #1;
      total++;
      if ({mem_en[0], mem_we[0], if_ack[0], dm_ack[0], stall_mem[0]} !== 5'b00001 ||
          {mem_addr[0], mem_wdata[0], if_rdata[0], dm_rdata[0]} !== 128'b0) begin
         bad++; $display("FAIL midrst_outputs got en=%b ack=%b addr=%h stall_mem=%b want 0 0 0 1",
                         mem_en[0], dm_ack[0], mem_addr[0], stall_mem[0]);
      end
      repeat (2) begin
         @(negedge clock); #1;
         total++;
         if (dm_ack[0] !== 1'b0 || mem_en[0] !== 1'b0) begin
            bad++; $display("FAIL midrst_hold got ack=%b en=%b want 0 0", dm_ack[0], mem_en[0]);
         end
      end
      @(negedge clock);
      resetn = 1;
      for (int c = 0; c < 8; c++) begin
         if (c > 0) @(negedge clock);
         #1;
         total++;
         if (mem_en[0] !== 1'(c == 1) || dm_ack[0] !== 1'(c == 4)) begin
            bad++; $display("FAIL midrst_reissue c=%0d got en=%b ack=%b want en=%b ack=%b", c, mem_en[0], dm_ack[0], c == 1, c == 4);
         end
         if (dm_ack[0]) begin
            total++;
            if (dm_rdata[0] !== mem_resp[0][64]) begin
               bad++; $display("FAIL midrst_rdata got %h want %h", dm_rdata[0], mem_resp[0][64]);
            end
            dm_req[0] = 0;
         end
      end
   endtask

   // Random traffic on both ports against a transaction-level model: each
   // grant reserves the memory until ack, IDLE resumes the cycle after ack.
   task automatic test_random(int k);
      int          lat = lat_of(k);
      int          next_idle = 0, issue_c = -10, ack_c = -10, if_gap = 0, dm_gap = 0;
      logic        last_i = 1, win_i = 0, is_st = 0, gd, gi;
      logic [31:0] x_addr = 0, x_wdata = 0, x_rdata = 0, exp_if = 0, exp_dm = 0;
      for (int i = 0; i < 256; i++) begin
         mem_resp[k][i] = $urandom;
         refm[k][i] = mem_resp[k][i];
      end
      do_reset();
      for (int c = 0; c < 300; c++) begin
         if (c > 0) @(negedge clock);
         if (if_req[k]) begin
            if (ack_c == c - 1 && win_i) begin
               if ($urandom_range(0, 1) == 1) if_addr[k] = rnd_addr();
               else begin if_req[k] = 0; if_gap = $urandom_range(0, 3); end
            end
         end else if (if_gap > 0) if_gap--;
         else if ($urandom_range(0, 1) == 1) begin if_req[k] = 1; if_addr[k] = rnd_addr(); end
         if (dm_req[k]) begin
            if (ack_c == c - 1 && !win_i) begin
               if ($urandom_range(0, 1) == 1) begin
                  dm_addr[k] = rnd_addr(); dm_we[k] = 1'($urandom_range(0, 1)); dm_wdata[k] = $urandom;
               end else begin dm_req[k] = 0; dm_gap = $urandom_range(0, 3); end
            end
         end else if (dm_gap > 0) dm_gap--;
         else if ($urandom_range(0, 1) == 1) begin
            dm_req[k] = 1; dm_addr[k] = rnd_addr(); dm_we[k] = 1'($urandom_range(0, 1)); dm_wdata[k] = $urandom;
         end
         if (c >= next_idle) begin
            gd = dm_req[k] && (!if_req[k] || last_i);
            gi = !gd && if_req[k];
            if (gd || gi) begin
               win_i   = gi;
               is_st   = gd && dm_we[k];
               x_addr  = gi ? if_addr[k] : dm_addr[k];
               issue_c = c + 1;
               ack_c   = c + 2 + (is_st ? 0 : lat);
               next_idle = ack_c + 1;
               last_i  = gi;
               if (is_st) begin x_wdata = dm_wdata[k]; refm[k][x_addr[9:2]] = x_wdata; end
               else x_rdata = refm[k][x_addr[9:2]];
            end
         end
         #1;
         if (c == ack_c && !is_st) begin
            if (win_i) exp_if = x_rdata;
            else exp_dm = x_rdata;
         end
         total++;
         if (mem_en[k] !== 1'(c == issue_c)) begin
            bad++; $display("FAIL rnd_mem_en lat=%0d c=%0d got %b want %b", lat, c, mem_en[k], c == issue_c);
         end
         if (c == issue_c) begin
            total++;
            if (mem_addr[k] !== x_addr || mem_we[k] !== is_st || (is_st && mem_wdata[k] !== x_wdata)) begin
               bad++; $display("FAIL rnd_issue lat=%0d c=%0d got addr=%h we=%b wd=%h want addr=%h we=%b wd=%h",
                               lat, c, mem_addr[k], mem_we[k], mem_wdata[k], x_addr, is_st, x_wdata);
            end
         end
         total++;
         if (if_ack[k] !== 1'(c == ack_c && win_i) || dm_ack[k] !== 1'(c == ack_c && !win_i)) begin
            bad++; $display("FAIL rnd_ack lat=%0d c=%0d got if=%b dm=%b want if=%b dm=%b",
                            lat, c, if_ack[k], dm_ack[k], c == ack_c && win_i, c == ack_c && !win_i);
         end
         total++;
         if (if_rdata[k] !== exp_if || dm_rdata[k] !== exp_dm) begin
            bad++; $display("FAIL rnd_rdata lat=%0d c=%0d got if=%h dm=%h want if=%h dm=%h",
                            lat, c, if_rdata[k], dm_rdata[k], exp_if, exp_dm);
         end
         total++;
         if (stall_if[k] !== 1'(if_req[k] && !(c == ack_c && win_i)) ||
             stall_mem[k] !== 1'(dm_req[k] && !(c == ack_c && !win_i))) begin
            bad++; $display("FAIL rnd_stall lat=%0d c=%0d got if=%b mem=%b", lat, c, stall_if[k], stall_mem[k]);
         end
      end
      @(negedge clock);
      clear_reqs();
   endtask

   initial begin
      resetn = 0;
      clear_reqs();
      for (int k = 0; k < NI; k++)
         for (int i = 0; i < 256; i++) mem_resp[k][i] = $urandom;
      mem_resp[0][4] = 32'h8C010004;
      test_reset();
      test_single_fetch();
      test_store();
      test_collision();
      test_back_to_back();
      test_reset_mid_wait();
      for (int k = 0; k < NI; k++) test_random(k);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
